nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
Upstream feeder for the 4-element, 4-bit sorting network. Accepts elements serially over a valid/ready stream and packs them into one N*W-bit word, first element in bits [W-1:0]. Presents that word from a holding register on a valid/ready output that drives the sorter's 16-bit input. A flush request closes a partial word early by padding the unused slots.

Parameters:
N, 4, elements per word; default matches the sorter.
W, 4, element width in bits.
PAD, 4'h0, fill value for unused slots on flush; width W.

Ports:
clk  in  1  clock, rising edge.
nrst  in  1  asynchronous active-low reset.
in_data  in  W  incoming element.
in_valid  in  1  in_data is valid.
in_ready  out  1  packer accepts in_data this cycle.
flush  in  1  close the current partial word; single-cycle pulse.
out_data  out  N*W  packed word; slot k occupies bits [k*W+W-1:k*W].
out_count  out  3  real elements in out_data, 1..N; width clog2(N+1).
out_valid  out  1  out_data/out_count are valid.
out_ready  in  1  downstream consumes the word this cycle.

Behaviour:
- State: assembly register asm (N*W), slot counter cnt (0..N-1), holding register (out_data, out_count, out_valid), flag flush_pend.
- Reset (nrst low, asynchronous): cnt=0, asm=0, out_data=0, out_count=0, out_valid=0, flush_pend=0; in_ready=0 while nrst low. A partial word is discarded on reset.
- Input accept: acc = in_valid && in_ready. On acc, in_data is written to slot cnt, then cnt increments.
- Holding register free: free = !out_valid || out_ready. Combinational path from out_ready to in_ready is allowed.
- in_ready = nrst && !flush_pend && (cnt != N-1 || free).
- Word complete: acc with cnt==N-1 loads obuf with {in_data, asm slots N-2..0} and out_count=N, then sets out_valid=1 and cnt=0. Latency: last element accepted in cycle t gives out_valid=1 in cycle t+1.
- Flush (flush=1 in cycle t):
  - The element accepted in the same cycle goes into its slot first. Let k be the resulting fill count.
  - k=0: flush ignored.
  - k=N: normal completion, no extra word.
  - 1<=k<=N-1 and free: obuf loads asm with slots k..N-1 set to PAD, out_count=k, out_valid=1, cnt=0.
  - 1<=k<=N-1 and not free: flush_pend=1 and in_ready=0. Padding and load happen in the first later cycle where free=1; that cycle clears flush_pend and sets cnt=0.
  - flush while flush_pend=1 has no further effect.
- Output: out_data/out_count stay stable while out_valid && !out_ready. On out_valid && out_ready, out_valid clears in the next cycle unless a new word loads in the same cycle; then out_valid stays 1 with the new data (back-to-back, full throughput of one element per cycle).
- Zero bubbles: with out_ready held at 1 and in_valid held at 1, in_ready never drops.
- asm slots at or above cnt hold stale data; only the load path applies PAD.
- Arithmetic: cnt wraps N-1 -> 0 only on completion or flush load; never increments past N-1.

Test Plan:
- Reset release, out_ready=1; stream 3,1,4,2 on consecutive cycles -> in_ready=1 throughout. One cycle after the 4th accept: out_data=16'h2413, out_count=4, out_valid=1 for exactly one cycle.
- Backpressure: out_ready=0; stream 1,2,3,4 -> out_data=16'h4321 held. Stream 5,6,7 -> accepted, in_ready then drops on the 8 pending. Raise out_ready -> 8 accepted in the same cycle; next cycle out_data=16'h8765, out_valid stays 1.
- Flush partial: out_ready=1, PAD=0; accept 9,A then flush -> out_data=16'h00A9, out_count=2. Next word starts at slot 0.
- Flush with same-cycle input: accept 5, then in_valid=1 with data 7 plus flush in one cycle -> out_data=16'h0075, out_count=2. Flush with cnt=0 and no input -> no word produced.
- Flush blocked: out_valid=1, out_ready=0, cnt=1 holding E, flush -> in_ready=0, flush_pend=1. Release out_ready -> next cycle out_data=16'h000E, out_count=1; in_ready returns to 1.
- Async reset mid-word: accept 1,2, pull nrst low mid-cycle -> out_valid=0 and in_ready=0 immediately. After release, stream 3,4,5,6 -> out_data=16'h6543 with no trace of 1,2.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: packs serial W-bit elements into N-slot words, with flush padding of partial words
module nibble_packer #(
   parameter int N = 4,
   parameter int W = 4,
   parameter logic [W-1:0] PAD = '0,
   localparam int CW = $clog2(N+1)
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [W-1:0]    in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic [N*W-1:0]  out_data,
   output logic [CW-1:0]   out_count,
   output logic            out_valid,
   input  logic            out_ready
);
   logic [N*W-1:0] asm, wr, padded;
   logic [CW-1:0] cnt, k;
   logic flush_pend, free, acc, complete, flush_now, load;
   assign free = !out_valid || out_ready;
   assign in_ready = nrst && !flush_pend && (cnt != CW'(N-1) || free);
   assign acc = in_valid && in_ready;
   assign k = cnt + CW'(acc);
   assign complete = acc && cnt == CW'(N-1);
   assign flush_now = flush && !flush_pend && k != '0 && k != CW'(N);
   assign load = complete || ((flush_now || flush_pend) && free);
   // merge this cycle's element into its slot, then pad every slot at or above the fill count
   always_comb begin
      wr = asm;
      if (acc) wr[int'(cnt)*W +: W] = in_data;
      padded = wr;
      for (int i = 0; i < N; i++) padded[i*W +: W] = (i < int'(k)) ? wr[i*W +: W] : PAD;
   end
   // assembly state, pending-flush flag and the output holding register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         asm        <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
         out_valid  <= 1'b0;
      end else begin
         asm        <= wr;
         cnt        <= load ? '0 : k;
         flush_pend <= free ? 1'b0 : (flush_pend || flush_now);
         out_valid  <= load || (out_valid && !out_ready);
         if (load) begin
            out_data  <= padded;
            out_count <= k;
         end
      end
   end
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_nibble_packer;
   logic clk = 0, nrst = 0, in_valid = 0, flush = 0, out_ready = 0, in_ready, out_valid;
   logic [3:0] in_data = '0;
   logic [15:0] out_data;
   logic [2:0] out_count;
   int errors = 0, checks = 0;
   logic [18:0] exp_q[$];

   nibble_packer dut (
      .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [15:0] d, input logic [2:0] c);
      exp_q.push_back({c, d});
   endtask

   // offer one element and return once it has been accepted (bounded wait)
   task automatic push(input logic [3:0] d, input bit must_ready);
      bit r;
      int n = 0;
      in_data = d;
      in_valid = 1;
      do begin
         @(negedge clk);
         r = in_ready;
         if (must_ready && n == 0) chk("in_ready_stream", 32'(r), 1);
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 50);
      if (!r) chk("push_timeout", 0, 1);
      in_valid = 0;
   endtask

   task automatic pulse_flush();
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor: every handshake on the output must match the oldest expected word
   always @(negedge clk) begin
      if (nrst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_word", {13'b0, out_count, out_data}, 32'h7ffff);
         else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[15:0]));
            chk("out_count", 32'(out_count), 32'(e[18:16]));
         end
      end
   end

   initial begin
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_count", 32'(out_count), 0);
      @(posedge clk);
      #1 nrst = 1;
      out_ready = 1;
      idle(1);
      // basic packing, first element lands in the low nibble
      expect_word(16'h2413, 4);
      push(4'h3, 1); push(4'h1, 1); push(4'h4, 1); push(4'h2, 1);
      chk("t1_valid_hi", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'h2413);
      idle(1);
      chk("t1_valid_one_cycle", 32'(out_valid), 0);
      // backpressure: second word fills behind a held first word
      out_ready = 0;
      expect_word(16'h4321, 4);
      expect_word(16'h8765, 4);
      push(4'h1, 1); push(4'h2, 1); push(4'h3, 1); push(4'h4, 1);
      push(4'h5, 1); push(4'h6, 1); push(4'h7, 1);
      chk("t2_held", 32'(out_data), 32'h4321);
      in_data = 4'h8;
      in_valid = 1;
      @(negedge clk);
      chk("t2_ready_drop", 32'(in_ready), 0);
      @(posedge clk);
      #1 out_ready = 1;
      @(negedge clk);
      chk("t2_ready_release", 32'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 0;
      chk("t2_b2b_valid", 32'(out_valid), 1);
      chk("t2_b2b_data", 32'(out_data), 32'h8765);
      idle(1);
      // flush of a two-element partial word
      expect_word(16'h00a9, 2);
      push(4'h9, 1); push(4'ha, 1);
      pulse_flush();
      chk("t3_data", 32'(out_data), 32'h00a9);
      chk("t3_count", 32'(out_count), 2);
      // the next word must start at slot 0
      expect_word(16'h4321, 4);
      push(4'h1, 1); push(4'h2, 1); push(4'h3, 1); push(4'h4, 1);
      idle(1);
      // flush together with an accepted element
      expect_word(16'h0075, 2);
      push(4'h5, 1);
      in_data = 4'h7;
      in_valid = 1;
      pulse_flush();
      in_valid = 0;
      chk("t4_data", 32'(out_data), 32'h0075);
      chk("t4_count", 32'(out_count), 2);
      idle(1);
      // flush of an empty word produces nothing
      pulse_flush();
      chk("t4_empty_flush", 32'(out_valid), 0);
      idle(2);
      chk("t4_empty_flush_late", 32'(out_valid), 0);
      // flush blocked behind a held word
      out_ready = 0;
      expect_word(16'h4321, 4);
      expect_word(16'h000e, 1);
      push(4'h1, 1); push(4'h2, 1); push(4'h3, 1); push(4'h4, 1);
      push(4'he, 1);
      pulse_flush();
      @(negedge clk);
      chk("t5_ready_blocked", 32'(in_ready), 0);
      chk("t5_flush_pend", 32'(dut.flush_pend), 1);
      chk("t5_still_held", 32'(out_data), 32'h4321);
      @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk);
      #1;
      chk("t5_data", 32'(out_data), 32'h000e);
      chk("t5_count", 32'(out_count), 1);
      chk("t5_ready_back", 32'(in_ready), 1);
      idle(1);
      // asynchronous reset discards a partial word
      push(4'h1, 1); push(4'h2, 1);
      #2 nrst = 0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 0);
      chk("t6_rst_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1 nrst = 1;
      expect_word(16'h6543, 4);
      push(4'h3, 1); push(4'h4, 1); push(4'h5, 1); push(4'h6, 1);
      chk("t6_data", 32'(out_data), 32'h6543);
      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
